mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the number of 32-bit data-memory words (power of two, 4..1024).
REQ-002 Parameter LATENCY, default 2, SHALL set the number of wait cycles per access (legal 1..15).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 MEM_MemRead  input  1  SHALL request a word load.
REQ-006 MEM_MemWrite  input  1  SHALL request a word store.
REQ-007 MEM_ALUresult  input  32  SHALL be the byte address.
REQ-008 MEM_WriteData  input  32  SHALL be the store data.
REQ-009 MEM_ReadData  output  32  SHALL be the registered load result presented to the MEM/WB register.
REQ-010 mem_stall_o  output  1  SHALL freeze PC, IF/ID, ID/EX and EX/MEM while high.
REQ-011 mem_misalign_o  output  1  SHALL flag a request with MEM_ALUresult[1:0] != 0 (combinational).
REQ-012 mem_busy_cnt_o  output  32  SHALL count stall cycles since reset.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-014 Valid request = (MEM_MemRead | MEM_MemWrite) & (MEM_ALUresult[1:0] == 0).
REQ-015 IDLE + valid request: capture address, data and op; load wait counter with LATENCY-1; go to WAIT.
REQ-016 IDLE + no valid request: stay in IDLE; the memory and MEM_ReadData SHALL NOT change.
REQ-017 WAIT: decrement the counter each cycle; when it is 0, go to DONE on the next edge.
REQ-018 On the WAIT->DONE edge, a store SHALL write the captured data to word index addr[log2(DEPTH)+1:2], and a load SHALL register that word into MEM_ReadData.
REQ-019 DONE SHALL go to IDLE unconditionally; the request still on the inputs during DONE SHALL NOT start a new access.
REQ-020 mem_stall_o SHALL be high combinationally in IDLE with a valid request and in all WAIT cycles, and low in DONE and idle IDLE; stall length = LATENCY+1 cycles.
REQ-021 MEM_ReadData SHALL hold its value until the next completed load; stores SHALL NOT alter it.
REQ-022 MEM_MemRead and MEM_MemWrite both high: perform the store and load the pre-write word into MEM_ReadData (read-before-write).
REQ-023 Misaligned request: no access, no stall, memory and MEM_ReadData unchanged, mem_misalign_o high for the cycle(s) present.
REQ-024 Address bits above log2(DEPTH)+1 SHALL be ignored (address wraps modulo DEPTH*4).
REQ-025 Input changes during WAIT SHALL be ignored; captured values govern the access.
REQ-026 mem_busy_cnt_o SHALL increment on every edge where mem_stall_o is high and saturate at 32'hFFFF_FFFF.

Reset
REQ-027 rst_i low SHALL immediately force: state IDLE, counter 0, MEM_ReadData 0, mem_busy_cnt_o 0, every memory word 0.
REQ-028 Reset asserted during WAIT SHALL discard the pending access; no memory write occurs.
REQ-029 After rst_i deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-030 LATENCY=2: store 32'hDEADBEEF to address 0x10 -> stall high 3 cycles, then low; a later load of 0x10 returns 32'hDEADBEEF in the DONE cycle.
REQ-031 Load from address 0x13 -> mem_misalign_o=1, mem_stall_o=0, MEM_ReadData unchanged.
REQ-032 DEPTH=256: store 32'h1 to address 0x400, load 0x000 -> returns 32'h1 (wrap).
REQ-033 Word 0x20 holds 32'hA, then read+write 32'hB to 0x20 -> MEM_ReadData=32'hA; a subsequent load returns 32'hB.
REQ-034 Reset pulse in the first WAIT cycle of a store of 32'h5 to 0x8 -> a later load of 0x8 returns 0; mem_busy_cnt_o restarts from 0.
REQ-035 Two back-to-back stores then one load (LATENCY=2) -> mem_busy_cnt_o=9, and each request accepted exactly once.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bus between the MEM stage and the data-memory access unit.
// The master side issues requests; the slave side returns data and stall status.
interface mem_access_unit_if;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [31:0] MEM_ALUresult;
  logic [31:0] MEM_WriteData;
  logic [31:0] MEM_ReadData;
  logic        mem_stall_o;
  logic        mem_misalign_o;
  logic [31:0] mem_busy_cnt_o;

  modport master (
    output MEM_MemRead,
    output MEM_MemWrite,
    output MEM_ALUresult,
    output MEM_WriteData,
    input  MEM_ReadData,
    input  mem_stall_o,
    input  mem_misalign_o,
    input  mem_busy_cnt_o
  );

  modport slave (
    input  MEM_MemRead,
    input  MEM_MemWrite,
    input  MEM_ALUresult,
    input  MEM_WriteData,
    output MEM_ReadData,
    output mem_stall_o,
    output mem_misalign_o,
    output mem_busy_cnt_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access unit for the MEM stage.
// Word-aligned loads/stores complete after LATENCY wait cycles.
module mem_access_unit #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_access_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;

  logic          rd_q;
  logic          wr_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   data_q;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata;
  logic [31:0] busy;

  logic req;
  logic aligned;
  logic valid;
  logic stall;
  logic capture;
  logic commit;
  logic unused_addr_hi;

  assign req     = bus.MEM_MemRead | bus.MEM_MemWrite;
  assign aligned = (bus.MEM_ALUresult[1:0] == 2'b00);
  assign valid   = req & aligned;

  // High address bits wrap: only the word index is kept
  assign unused_addr_hi = ^bus.MEM_ALUresult[31:AW+2];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    capture  = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid) begin
          stall    = 1'b1;
          capture  = 1'b1;
          cnt_nx   = LAT_M1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          commit   = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= 32'd0;
    end else if (capture) begin
      rd_q   <= bus.MEM_MemRead;
      wr_q   <= bus.MEM_MemWrite;
      idx_q  <= bus.MEM_ALUresult[AW+1:2];
      data_q <= bus.MEM_WriteData;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (commit && wr_q) begin
      mem[idx_q] <= data_q;
    end
  end

  // Same-edge read sees the pre-write word
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata <= 32'd0;
    end else if (commit && rd_q) begin
      rdata <= mem[idx_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy <= 32'd0;
    end else if (stall && (busy != 32'hFFFF_FFFF)) begin
      busy <= busy + 32'd1;
    end
  end

  assign bus.MEM_ReadData   = rdata;
  assign bus.mem_stall_o    = stall;
  assign bus.mem_misalign_o = req & ~aligned;
  assign bus.mem_busy_cnt_o = busy;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/busy sequences,
// and random accesses against a word-array reference model.
module tb_mem_access_unit;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rd;
  logic [31:0] ref_busy;

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    ref_rd   = 32'd0;
    ref_busy = 32'd0;
  endtask

  task automatic set_idle();
    bus.MEM_MemRead   = 1'b0;
    bus.MEM_MemWrite  = 1'b0;
    bus.MEM_ALUresult = 32'd0;
    bus.MEM_WriteData = 32'd0;
  endtask

  // One request, held until the unit finishes; optional input noise in WAIT.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit scramble, input string tag,
                        output logic [31:0] got);
    int len;
    int idx;
    @(negedge clk);
    bus.MEM_MemRead   = rd;
    bus.MEM_MemWrite  = wr;
    bus.MEM_ALUresult = addr;
    bus.MEM_WriteData = data;
    #1;
    if (addr[1:0] != 2'b00) begin
      check32({tag, " misalign"}, 32'(bus.mem_misalign_o), 32'd1);
      check32({tag, " mis stall"}, 32'(bus.mem_stall_o), 32'd0);
      @(negedge clk);
      #1;
      check32({tag, " mis stall2"}, 32'(bus.mem_stall_o), 32'd0);
      set_idle();
      got = bus.MEM_ReadData;
      check32({tag, " mis rdata"}, got, ref_rd);
      check32({tag, " mis busy"}, bus.mem_busy_cnt_o, ref_busy);
      return;
    end
    check32({tag, " no misalign"}, 32'(bus.mem_misalign_o), 32'd0);
    len = 0;
    while (bus.mem_stall_o === 1'b1 && len < 40) begin
      len++;
      if (scramble && len >= 2) begin
        bus.MEM_MemRead   = 1'($urandom);
        bus.MEM_MemWrite  = 1'($urandom);
        bus.MEM_ALUresult = $urandom;
        bus.MEM_WriteData = $urandom;
      end
      @(negedge clk);
      #1;
    end
    idx = int'((addr >> 2) % DEPTH);
    if (rd) ref_rd = ref_mem[idx];
    if (wr) ref_mem[idx] = data;
    ref_busy = ref_busy + 32'(LATENCY + 1);
    got = bus.MEM_ReadData;
    check32({tag, " stall len"}, 32'(len), 32'(LATENCY + 1));
    check32({tag, " rdata"}, got, ref_rd);
    check32({tag, " busy"}, bus.mem_busy_cnt_o, ref_busy);
    if (scramble) set_idle();
    @(negedge clk);
    set_idle();
    #1;
    check32({tag, " no restart"}, 32'(bus.mem_stall_o), 32'd0);
    check32({tag, " rdata hold"}, bus.MEM_ReadData, ref_rd);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    #2;
    model_reset();
    check32({tag, " rst rdata"}, bus.MEM_ReadData, 32'd0);
    check32({tag, " rst busy"}, bus.mem_busy_cnt_o, 32'd0);
    check32({tag, " rst stall"}, 32'(bus.mem_stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t        vt [12];
  logic [31:0] got;
  logic [31:0] a;
  int          op;

  initial begin
    vt[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_BEEF};
    vt[3]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0001, 32'hDEAD_BEEF};
    vt[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001};
    vt[5]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_000A, 32'h0000_0001};
    vt[6]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_000B, 32'h0000_000A};
    vt[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_000B};
    vt[8]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_0077, 32'h0000_000B};
    vt[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
    vt[10] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    vt[11] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFF};

    set_idle();
    model_reset();
    #1;
    check32("reset rdata", bus.MEM_ReadData, 32'd0);
    check32("reset busy", bus.mem_busy_cnt_o, 32'd0);
    check32("reset stall", 32'(bus.mem_stall_o), 32'd0);
    check32("reset misalign", 32'(bus.mem_misalign_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data, 1'b0,
             $sformatf("vec%0d", i), got);
      check32($sformatf("vec%0d table", i), got, vt[i].exp_rd);
    end

    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, "scr0", got);
    check32("scr0 value", got, 32'hDEAD_BEEF);

    for (int i = 0; i < 150; i++) begin
      op = int'($urandom % 3);
      a = $urandom & 32'hFFFF_FC00;
      a[5:2] = 4'($urandom);
      a[1:0] = (($urandom % 5) == 0) ? 2'($urandom) : 2'b00;
      access(op != 1, op != 0, a, $urandom, 1'($urandom),
             $sformatf("rnd%0d", i), got);
      repeat ($urandom % 3) @(negedge clk);
    end

    do_reset("b2b");
    access(1'b0, 1'b1, 32'h0000_0040, 32'h1, 1'b0, "b2b s0", got);
    access(1'b0, 1'b1, 32'h0000_0044, 32'h2, 1'b0, "b2b s1", got);
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, "b2b l0", got);
    check32("b2b busy9", bus.mem_busy_cnt_o, 32'd9);
    check32("b2b load", got, 32'h1);

    do_reset("pre34");
    @(negedge clk);
    bus.MEM_MemWrite  = 1'b1;
    bus.MEM_ALUresult = 32'h0000_0008;
    bus.MEM_WriteData = 32'h0000_0005;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    set_idle();
    #1;
    check32("wait rst busy", bus.mem_busy_cnt_o, 32'd0);
    check32("wait rst stall", 32'(bus.mem_stall_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, "post rst 8", got);
    check32("discarded store", got, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, "post rst 40", got);
    check32("mem cleared", got, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
